// File: rtl/activation_writeback.sv
// rtl/activation_writeback.sv - requantize activation results to int8, pack, buffer and write to unified buffer
//
// Purpose: sinks the activation-stage result stream (no backpressure), saturates each
// 32-bit signed result to int8 after an arithmetic right shift, packs four per word
// (lane0 = bits[7:0]), queues words in a FIFO and writes them to consecutive
// unified-buffer addresses over a valid/ready port.
//
// Optional feature macro: ACT_WB_ROUND_EN (round half up before the shift).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, length,  job launch and parameters (sampled in IDLE)
//   shift
//   valid_in, data_in          activation result stream
//   wr_valid, wr_ready,        unified-buffer write port
//   wr_addr, wr_data
//   busy, done, overflow       job status to the controller
module activation_writeback #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [4:0]        shift,
  input  logic              valid_in,
  input  logic [31:0]       data_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [4:0]        shift_q;
  logic [1:0]        lane_q;
  logic [31:0]       pack_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ovf_q;
  logic [PW-1:0]     rptr_q, wptr_q;
  logic [PW:0]       count_q;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic              start_go, accept, last, push, pop, full, push_ok;
  logic signed [32:0] shifted;
  logic [7:0]        q8;
  logic [31:0]       word;

  // Requantization. Working at 33 bits keeps the rounded sum from wrapping and
  // lets both builds share the same saturation compare.
`ifdef ACT_WB_ROUND_EN
  logic signed [32:0] bias;
  always_comb begin
    bias    = (shift_q != 5'd0) ? (33'sd1 <<< (shift_q - 5'd1)) : 33'sd0;
    shifted = ($signed({data_in[31], data_in}) + bias) >>> shift_q;
  end
`else
  always_comb begin
    shifted = $signed({data_in[31], data_in}) >>> shift_q;
  end
`endif

  always_comb begin
    if (shifted > 33'sd127)       q8 = 8'h7F;
    else if (shifted < -33'sd128) q8 = 8'h80;
    else                          q8 = shifted[7:0];
  end

  assign start_go = (state_q == S_IDLE) && start;
  assign accept   = (state_q == S_RUN) && valid_in;
  assign last     = (cnt_q == len_q - LEN_W'(1));
  // Lanes above the current one are still zero because pack_q is cleared on every push.
  assign word     = pack_q | ({24'b0, q8} << {lane_q, 3'b000});
  assign push     = accept && ((lane_q == 2'd3) || last);

  assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
  assign wr_valid = (count_q != '0);
  assign pop      = wr_valid && wr_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok  = push && (!full || pop);
  assign wr_data  = wr_valid ? mem_q[rptr_q] : 32'h0;
  assign wr_addr  = addr_q;
  assign overflow = ovf_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (length != '0) ? S_RUN : S_DONE;
      S_RUN:   if (accept && last) state_d = S_FLUSH;
      S_FLUSH: if (count_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Job parameters, element packing, address and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (start_go) begin
        len_q   <= length;
        shift_q <= shift;
        cnt_q   <= '0;
        lane_q  <= '0;
        pack_q  <= '0;
        ovf_q   <= 1'b0;
      end else if (accept) begin
        cnt_q  <= cnt_q + LEN_W'(1);
        lane_q <= last ? 2'd0 : lane_q + 2'd1;
        pack_q <= push ? 32'h0 : word;
      end

      if (push && !push_ok) ovf_q <= 1'b1;

      if (start_go)  addr_q <= base_addr;
      else if (pop)  addr_q <= addr_q + ADDR_W'(1);

      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end

  // FIFO storage needs no reset: wr_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= word;
  end

endmodule
